// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: round-robin two-master Wishbone arbiter with ack watchdog in front of the SDRAM controller slave port
module wb_sdram_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              RESET,
  input  logic              sdr_init_done,
  input  logic [1:0]        m_wb_cyc_i,
  input  logic [1:0]        m_wb_stb_i,
  input  logic [1:0]        m_wb_we_i,
  input  logic [2*AW-1:0]   m_wb_addr_i,
  input  logic [2*DW-1:0]   m_wb_dat_i,
  input  logic [2*DW/8-1:0] m_wb_sel_i,
  input  logic [5:0]        m_wb_cti_i,
  output logic [DW-1:0]     m_wb_dat_o,
  output logic [1:0]        m_wb_ack_o,
  output logic [1:0]        m_wb_err_o,
  output logic              s_wb_cyc_o,
  output logic              s_wb_stb_o,
  output logic              s_wb_we_o,
  output logic [AW-1:0]     s_wb_addr_o,
  output logic [DW-1:0]     s_wb_dat_o,
  output logic [DW/8-1:0]   s_wb_sel_o,
  output logic [2:0]        s_wb_cti_o,
  input  logic [DW-1:0]     s_wb_dat_i,
  input  logic              s_wb_ack_i,
  output logic [1:0]        gnt_o,
  output logic              timeout_sticky_o,
  output logic [7:0]        timeout_cnt_o
);
  localparam int SW = DW / 8;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ABORT} state_t;
  state_t     r_state;
  logic       r_owner;
  logic       r_last;
  logic [7:0] r_wd;
  logic [1:0] r_gnt;
  logic [1:0] r_err;
  logic       r_sticky;
  logic [7:0] r_tcnt;
  logic [1:0] w_req;
  logic       w_pick;
  logic       w_act;
  assign w_req  = m_wb_cyc_i & m_wb_stb_i;
  assign w_pick = &w_req ? ~r_last : w_req[1];
  assign w_act  = r_state == S_GRANT;
  assign s_wb_cyc_o  = w_act & m_wb_cyc_i[r_owner];
  assign s_wb_stb_o  = w_act & m_wb_stb_i[r_owner];
  assign s_wb_we_o   = w_act & m_wb_we_i[r_owner];
  assign s_wb_addr_o = !w_act ? '0 : r_owner ? m_wb_addr_i[2*AW-1:AW] : m_wb_addr_i[AW-1:0];
  assign s_wb_dat_o  = !w_act ? '0 : r_owner ? m_wb_dat_i[2*DW-1:DW] : m_wb_dat_i[DW-1:0];
  assign s_wb_sel_o  = !w_act ? '0 : r_owner ? m_wb_sel_i[2*SW-1:SW] : m_wb_sel_i[SW-1:0];
  assign s_wb_cti_o  = !w_act ? '0 : r_owner ? m_wb_cti_i[5:3] : m_wb_cti_i[2:0];
  assign m_wb_ack_o  = w_act ? {r_owner, ~r_owner} & {2{s_wb_ack_i}} : 2'b00;
  assign m_wb_dat_o  = s_wb_dat_i;
  assign m_wb_err_o  = r_err;
  assign gnt_o       = r_gnt;
  assign timeout_sticky_o = r_sticky;
  assign timeout_cnt_o    = r_tcnt;
  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_wd     <= '0;
      r_gnt    <= 2'b00;
      r_err    <= 2'b00;
      r_sticky <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      r_err <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (sdr_init_done && |w_req) begin
            r_state <= S_GRANT;
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_gnt   <= w_pick ? 2'b10 : 2'b01;
            r_wd    <= '0;
          end
        end
        S_GRANT: begin
          if (!m_wb_cyc_i[r_owner]) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'b00;
          end else if (s_wb_ack_i || !m_wb_stb_i[r_owner]) begin
            r_wd <= '0;
          end else if (r_wd == 8'(TIMEOUT - 1)) begin
            r_state  <= S_ABORT;
            r_gnt    <= 2'b00;
            r_err    <= r_owner ? 2'b10 : 2'b01;
            r_sticky <= 1'b1;
            r_tcnt   <= r_tcnt == 8'hff ? r_tcnt : r_tcnt + 8'd1;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_last  <= r_owner;
          r_wd    <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: randomized scoreboard bench for the two-master SDRAM Wishbone arbiter
module tb_wb_sdram_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 64;
  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [2:0]    c;
    logic          last;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b0;
  logic [1:0] cyc = '0;
  logic [1:0] stb = '0;
  logic [1:0] we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*DW-1:0] wdat = '0;
  logic [2*SW-1:0] sel = '0;
  logic [5:0] cti = '0;
  logic [DW-1:0] m_dat;
  logic [1:0] ack;
  logic [1:0] err;
  logic [1:0] gnt;
  logic s_cyc;
  logic s_stb;
  logic s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel;
  logic [2:0] s_cti;
  logic [DW-1:0] sl_dat;
  logic sl_ack;
  logic sl_hang = 1'b0;
  logic sticky;
  logic [7:0] tcnt;
  int total = 0;
  int bad = 0;
  beat_t mq[2][$];
  beat_t exp_q[2][$];
  bit gap[2];
  bit started[2];
  int ackcnt[2];
  int errcnt[2];
  logic [1:0] glog[$];
  int own = -1;
  int ab = -1;
  int last = 1;
  int stall = 0;
  int mcnt = 0;
  bit msticky = 1'b0;
  wb_sdram_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .sys_clk(clk), .RESET(rst), .sdr_init_done(init),
    .m_wb_cyc_i(cyc), .m_wb_stb_i(stb), .m_wb_we_i(we), .m_wb_addr_i(addr),
    .m_wb_dat_i(wdat), .m_wb_sel_i(sel), .m_wb_cti_i(cti),
    .m_wb_dat_o(m_dat), .m_wb_ack_o(ack), .m_wb_err_o(err),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_addr_o(s_addr),
    .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel), .s_wb_cti_o(s_cti),
    .s_wb_dat_i(sl_dat), .s_wb_ack_i(sl_ack),
    .gnt_o(gnt), .timeout_sticky_o(sticky), .timeout_cnt_o(tcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(int m, bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s, logic [2:0] c, bit l);
    beat_t b;
    b.we = w;
    b.a = a;
    b.d = d;
    b.s = s;
    b.c = c;
    b.last = l;
    mq[m].push_back(b);
    exp_q[m].push_back(b);
  endtask
  task automatic burst(int m, bit w, logic [AW-1:0] a, int n);
    for (int i = 0; i < n; i++)
      issue(m, w, a + AW'(i), $urandom, SW'($urandom), i == n - 1 ? 3'b111 : 3'b010, i == n - 1);
  endtask
  task automatic drain(int maxc);
    int n = 0;
    while ((mq[0].size() != 0 || mq[1].size() != 0 || gnt != 2'b00) && n < maxc) begin
      tick(1);
      n++;
    end
    chk("drain_bound", n < maxc, 1);
    tick(3);
  endtask
  task automatic chk_order(string nm, string ord);
    chk({nm, "_len"}, glog.size(), ord.len());
    for (int i = 0; i < ord.len() && i < glog.size(); i++)
      chk(nm, glog[i], ord[i] == 8'h31 ? 2'b10 : 2'b01);
  endtask
  initial begin
    sl_ack = 1'b0;
    sl_dat = '0;
    forever begin
      @(posedge clk);
      #3;
      sl_dat = $urandom;
      sl_ack = s_cyc && s_stb && !sl_hang && $urandom_range(0, 1) == 1;
    end
  end
  initial begin
    beat_t b;
    forever begin
      @(posedge clk);
      #2;
      for (int m = 0; m < 2; m++) begin
        if (mq[m].size() > 0 && !gap[m]) begin
          b = mq[m][0];
          cyc[m] = 1'b1;
          stb[m] = !(started[m] && $urandom_range(0, 3) == 0);
          we[m] = b.we;
          addr[m*AW +: AW] = b.a;
          wdat[m*DW +: DW] = b.d;
          sel[m*SW +: SW] = b.s;
          cti[m*3 +: 3] = b.c;
        end else begin
          cyc[m] = 1'b0;
          stb[m] = 1'b0;
          gap[m] = 1'b0;
        end
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          mq[m].delete();
          gap[m] = 1'b0;
          started[m] = 1'b0;
        end else if (cyc[m] && stb[m] && (ack[m] || err[m]) && mq[m].size() > 0) begin
          b = mq[m].pop_front();
          gap[m] = b.last || err[m];
          started[m] = !gap[m];
        end
      end
    end
  end
  initial begin
    logic [1:0] eg;
    logic [1:0] ee;
    logic [1:0] pg;
    logic [1:0] req;
    logic [67:0] eb;
    beat_t e;
    pg = 2'b00;
    forever begin
      @(negedge clk);
      eg = 2'b00;
      ee = 2'b00;
      eb = '0;
      if (own >= 0) begin
        eg[own] = 1'b1;
        eb = {cyc[own], stb[own], we[own], addr[own*AW +: AW], wdat[own*DW +: DW], sel[own*SW +: SW], cti[own*3 +: 3]};
      end
      if (ab >= 0) ee[ab] = 1'b1;
      chk("gnt", gnt, eg);
      chk("ack", ack, sl_ack ? eg : 2'b00);
      chk("err", err, ee);
      chk("s_bus", {s_cyc, s_stb, s_we, s_addr, s_dat_o, s_sel, s_cti}, eb);
      chk("sticky", sticky, msticky);
      chk("tcnt", tcnt, mcnt);
      if (own >= 0 && s_cyc && s_stb && sl_ack) begin
        ackcnt[own]++;
        chk("rdat", m_dat, sl_dat);
        if (exp_q[own].size() == 0) chk("sb_underflow", 0, 1);
        else begin
          e = exp_q[own].pop_front();
          chk("beat", {s_we, s_addr, s_dat_o, s_sel, s_cti}, {e.we, e.a, e.d, e.s, e.c});
        end
      end
      if (ab >= 0) begin
        errcnt[ab]++;
        if (exp_q[ab].size() > 0) e = exp_q[ab].pop_front();
      end
      if (gnt != 2'b00 && pg == 2'b00) glog.push_back(gnt);
      pg = gnt;
      req = cyc & stb;
      if (rst) begin
        own = -1;
        ab = -1;
        last = 1;
        stall = 0;
        mcnt = 0;
        msticky = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
      end else if (ab >= 0) begin
        last = ab;
        ab = -1;
      end else if (own < 0) begin
        if (init && req != 2'b00) begin
          own = req == 2'b11 ? 1 - last : (req[1] ? 1 : 0);
          last = own;
          stall = 0;
        end
      end else if (!cyc[own]) begin
        own = -1;
      end else if (sl_ack || !stb[own]) begin
        stall = 0;
      end else begin
        stall++;
        if (stall == TO) begin
          ab = own;
          own = -1;
          stall = 0;
          msticky = 1'b1;
          if (mcnt < 255) mcnt++;
        end
      end
    end
  end
  initial begin
    int b;
    int n;
    tick(3);
    rst = 1'b0;
    tick(1);
    glog.delete();
    issue(0, 0, 26'h10, 32'h0, 4'hF, 3'b111, 1);
    issue(1, 0, 26'h20, 32'h0, 4'hF, 3'b111, 1);
    tick(20);
    chk("init_gate_gnt", glog.size(), 0);
    chk("init_gate_cyc", s_cyc, 0);
    init = 1'b1;
    tick(1);
    chk("init_first_gnt", gnt, 2'b01);
    drain(200);
    chk_order("init_order", "01");
    glog.delete();
    b = ackcnt[1];
    issue(1, 1, 26'h0000A5, 32'hDEADBEEF, 4'hF, 3'b111, 1);
    drain(200);
    chk_order("wr_order", "1");
    chk("wr_acks", ackcnt[1] - b, 1);
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 26'h40 + AW'(i), $urandom, 4'hF, 3'b111, 1);
      issue(1, 0, 26'h80 + AW'(i), $urandom, 4'hF, 3'b111, 1);
    end
    drain(500);
    chk_order("rr_order", "01010101");
    glog.delete();
    b = ackcnt[0];
    burst(0, 0, 26'h100, 4);
    issue(1, 0, 26'h200, 32'h0, 4'hF, 3'b111, 1);
    drain(500);
    chk_order("burst_order", "01");
    chk("burst_beats", ackcnt[0] - b, 4);
    glog.delete();
    sl_hang = 1'b1;
    b = errcnt[1];
    issue(1, 1, 26'h3FF, 32'h12345678, 4'h3, 3'b111, 1);
    drain(300);
    chk("to_err", errcnt[1] - b, 1);
    chk("to_sticky", sticky, 1);
    chk("to_cnt", tcnt, 1);
    sl_hang = 1'b0;
    issue(0, 0, 26'h300, 32'h0, 4'hF, 3'b111, 1);
    drain(300);
    chk_order("to_order", "10");
    b = ackcnt[0];
    burst(0, 0, 26'h400, 4);
    n = 0;
    while (ackcnt[0] < b + 1 && n < 100) begin
      tick(1);
      n++;
    end
    chk("rst_wait", n < 100, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_outputs", {gnt, ack, err, s_cyc, s_stb, s_we, s_addr, s_dat_o, s_sel, s_cti, sticky, tcnt}, '0);
    rst = 1'b0;
    tick(2);
    glog.delete();
    issue(0, 0, 26'h500, 32'h0, 4'hF, 3'b111, 1);
    issue(1, 0, 26'h600, 32'h0, 4'hF, 3'b111, 1);
    drain(300);
    chk_order("rst_tie", "01");
    for (int i = 0; i < 150; i++) begin
      burst($urandom_range(0, 1), 1'($urandom_range(0, 1)), AW'($urandom), $urandom_range(1, 4));
      init = 1'b1;
      n = 0;
      while (mq[0].size() + mq[1].size() > 10 && n < 1000) begin
        tick(1);
        n++;
      end
      init = $urandom_range(0, 7) != 0;
      tick($urandom_range(0, 4));
    end
    init = 1'b1;
    drain(5000);
    chk("rand_sb_empty", exp_q[0].size() + exp_q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
